// File: rtl/image_scaler_ctrl.sv
// Image scaler control: walks the destination raster, maps each pixel back to a
// source pixel (x2/x4 zoom or decimation), fetches it through a one-entry cache and writes it out.
module image_scaler_ctrl #(
    parameter int SRC_W  = 160,
    parameter int SRC_H  = 120,
    parameter int PIX_W  = 8,
    parameter int SRC_AW = 15,
    parameter int DST_AW = 19
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              btn_start,
    input  logic [1:0]        sw_mode,
    input  logic              abort,
    output logic              rd_req,
    output logic [SRC_AW-1:0] rd_addr,
    input  logic              rd_valid,
    input  logic [PIX_W-1:0]  rd_data,
    output logic              wr_req,
    output logic [DST_AW-1:0] wr_addr,
    output logic [PIX_W-1:0]  wr_data,
    input  logic              wr_ready,
    output logic [2:0]        current_state,
    output logic              busy,
    output logic              processing_done
);

    typedef enum logic [2:0] {
        IDLE    = 3'b000,
        CONFIG  = 3'b001,
        FETCH   = 3'b010,
        PROCESS = 3'b011,
        WRITE   = 3'b100,
        DONE    = 3'b101
    } state_t;

    state_t            state, state_nxt;
    logic              btn_q, btn_armed, start_edge;
    logic              down_q;
    logic [1:0]        shift_k, cfg_k;
    logic [DST_AW-1:0] dst_w, dst_h, dx, dy, sx, sy;
    logic              cache_vld, cache_hit, last_pix;
    logic [SRC_AW-1:0] cache_addr;
    logic [PIX_W-1:0]  cache_data;

    // Destination dimension from a source dimension; decimation floors.
    function automatic logic [DST_AW-1:0] scale_dim(input logic [DST_AW-1:0] v,
                                                    input logic down, input logic [1:0] k);
        return down ? (v >> k) : (v << k);
    endfunction

    // Source coordinate from a destination coordinate (inverse of scale_dim).
    function automatic logic [DST_AW-1:0] map_coord(input logic [DST_AW-1:0] d,
                                                    input logic down, input logic [1:0] k);
        return down ? (d << k) : (d >> k);
    endfunction

    // btn_armed blocks a start from a button already held high when reset releases.
    assign start_edge = btn_start && !btn_q && btn_armed;

    always_comb begin
        sx        = map_coord(dx, down_q, shift_k);
        sy        = map_coord(dy, down_q, shift_k);
        rd_addr   = SRC_AW'(sy) * SRC_AW'(SRC_W) + SRC_AW'(sx);
        cache_hit = cache_vld && (cache_addr == rd_addr);
        last_pix  = (dx == dst_w - DST_AW'(1)) && (dy == dst_h - DST_AW'(1));
        cfg_k     = sw_mode[0] ? 2'd2 : 2'd1;
    end

    assign current_state   = state;
    assign busy            = (state != IDLE);
    assign rd_req          = (state == FETCH) && !cache_hit;
    assign wr_req          = (state == WRITE);
    assign processing_done = (state == DONE);

    always_comb begin
        state_nxt = IDLE;
        case (state)
            IDLE:    state_nxt = start_edge ? CONFIG : IDLE;
            CONFIG:  state_nxt = FETCH;
            FETCH:   state_nxt = (cache_hit || rd_valid) ? PROCESS : FETCH;
            PROCESS: state_nxt = WRITE;
            WRITE:   state_nxt = wr_ready ? (last_pix ? DONE : FETCH) : WRITE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (abort && (state != IDLE))
            state_nxt = IDLE;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            btn_q      <= 1'b0;
            btn_armed  <= 1'b0;
            down_q     <= 1'b0;
            shift_k    <= 2'd0;
            dst_w      <= '0;
            dst_h      <= '0;
            dx         <= '0;
            dy         <= '0;
            cache_vld  <= 1'b0;
            cache_addr <= '0;
            cache_data <= '0;
            wr_addr    <= '0;
            wr_data    <= '0;
        end else begin
            btn_q <= btn_start;
            if (!btn_start)
                btn_armed <= 1'b1;
            if (!abort) begin
                case (state)
                    CONFIG: begin
                        down_q    <= sw_mode[1];
                        shift_k   <= cfg_k;
                        dst_w     <= scale_dim(DST_AW'(SRC_W), sw_mode[1], cfg_k);
                        dst_h     <= scale_dim(DST_AW'(SRC_H), sw_mode[1], cfg_k);
                        dx        <= '0;
                        dy        <= '0;
                        cache_vld <= 1'b0;
                    end
                    FETCH: begin
                        if (!cache_hit && rd_valid) begin
                            cache_vld  <= 1'b1;
                            cache_addr <= rd_addr;
                            cache_data <= rd_data;
                        end
                    end
                    PROCESS: begin
                        wr_data <= cache_data;
                        wr_addr <= dy * dst_w + dx;
                    end
                    WRITE: begin
                        if (wr_ready && !last_pix) begin
                            if (dx == dst_w - DST_AW'(1)) begin
                                dx <= '0;
                                dy <= dy + DST_AW'(1);
                            end else begin
                                dx <= dx + DST_AW'(1);
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_image_scaler_ctrl.sv
// Bench for image_scaler_ctrl: two instances (4x2 and 7x5 sources) driven by a
// memory/sink responder and checked against a raster-order reference model.
module tb_image_scaler_ctrl;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       btn_a, btn_b;
    logic [1:0] sw_mode;
    logic       abort, rd_valid, wr_ready;
    logic [7:0] rd_data;

    logic       rd_req_a, wr_req_a, busy_a, done_a;
    logic [2:0] st_a;
    logic [2:0] rd_addr_a;
    logic [6:0] wr_addr_a;
    logic [7:0] wr_data_a;

    logic       rd_req_b, wr_req_b, busy_b, done_b;
    logic [2:0] st_b;
    logic [5:0] rd_addr_b;
    logic [9:0] wr_addr_b;
    logic [7:0] wr_data_b;

    logic       sel_v;
    logic       rd_req_v, wr_req_v, busy_v, done_v;
    logic [2:0] st_v;
    logic [5:0] rd_addr_v;
    logic [9:0] wr_addr_v;
    logic [7:0] wr_data_v;

    int checks = 0;
    int errors = 0;
    int exp_wa[$];
    int exp_src[$];
    int exp_rd[$];

    always #5 clk = ~clk;

    image_scaler_ctrl #(.SRC_W(4), .SRC_H(2), .PIX_W(8), .SRC_AW(3), .DST_AW(7)) dut_a (
        .clk(clk), .reset_n(reset_n), .btn_start(btn_a), .sw_mode(sw_mode), .abort(abort),
        .rd_req(rd_req_a), .rd_addr(rd_addr_a), .rd_valid(rd_valid), .rd_data(rd_data),
        .wr_req(wr_req_a), .wr_addr(wr_addr_a), .wr_data(wr_data_a), .wr_ready(wr_ready),
        .current_state(st_a), .busy(busy_a), .processing_done(done_a));

    image_scaler_ctrl #(.SRC_W(7), .SRC_H(5), .PIX_W(8), .SRC_AW(6), .DST_AW(10)) dut_b (
        .clk(clk), .reset_n(reset_n), .btn_start(btn_b), .sw_mode(sw_mode), .abort(abort),
        .rd_req(rd_req_b), .rd_addr(rd_addr_b), .rd_valid(rd_valid), .rd_data(rd_data),
        .wr_req(wr_req_b), .wr_addr(wr_addr_b), .wr_data(wr_data_b), .wr_ready(wr_ready),
        .current_state(st_b), .busy(busy_b), .processing_done(done_b));

    assign st_v      = sel_v ? st_b : st_a;
    assign rd_req_v  = sel_v ? rd_req_b : rd_req_a;
    assign wr_req_v  = sel_v ? wr_req_b : wr_req_a;
    assign busy_v    = sel_v ? busy_b : busy_a;
    assign done_v    = sel_v ? done_b : done_a;
    assign rd_addr_v = sel_v ? rd_addr_b : 6'(rd_addr_a);
    assign wr_addr_v = sel_v ? wr_addr_b : 10'(wr_addr_a);
    assign wr_data_v = sel_v ? wr_data_b : wr_data_a;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] memval(input int a, input int s);
        return 8'((a * 53 + s * 7 + 11) & 255);
    endfunction

    task automatic chk_zero(input string tag);
        chk({tag, "_state"}, 64'(st_v), 64'(0));
        chk({tag, "_busy"}, 64'(busy_v), 64'(0));
        chk({tag, "_rd_req"}, 64'(rd_req_v), 64'(0));
        chk({tag, "_wr_req"}, 64'(wr_req_v), 64'(0));
        chk({tag, "_done"}, 64'(done_v), 64'(0));
        chk({tag, "_rd_addr"}, 64'(rd_addr_v), 64'(0));
        chk({tag, "_wr_addr"}, 64'(wr_addr_v), 64'(0));
        chk({tag, "_wr_data"}, 64'(wr_data_v), 64'(0));
    endtask

    // One complete job: rd_lat/wr_lat < 0 means random 0..3 cycles of wait per handshake.
    task automatic run_job(input bit sel, input logic [1:0] mode, input int rd_lat,
                           input int wr_lat, input int abort_at, input bit chaos,
                           input int salt, output int nrd, output int nwr);
        int w, h, f, dw, dh, cyc, wait_rd, wait_wr, cur_rl, cur_wl, done_cnt;
        bit fin, aborted;
        w  = sel ? 7 : 4;
        h  = sel ? 5 : 2;
        f  = mode[0] ? 4 : 2;
        dw = mode[1] ? w / f : w * f;
        dh = mode[1] ? h / f : h * f;
        exp_wa.delete();
        exp_src.delete();
        exp_rd.delete();
        for (int y = 0; y < dh; y++)
            for (int x = 0; x < dw; x++) begin
                int s;
                s = mode[1] ? (y * f) * w + x * f : (y / f) * w + x / f;
                exp_wa.push_back(y * dw + x);
                exp_src.push_back(s);
                if (exp_rd.size() == 0 || exp_rd[exp_rd.size() - 1] != s)
                    exp_rd.push_back(s);
            end

        @(negedge clk);
        sel_v = sel; sw_mode = mode; abort = 0; rd_valid = 0; wr_ready = 0;
        btn_a = 0; btn_b = 0;
        @(negedge clk);
        chk("idle_before_start", 64'(st_v), 64'(0));
        if (sel) btn_b = 1; else btn_a = 1;
        @(negedge clk);
        chk("config_after_edge", 64'(st_v), 64'(1));

        nrd = 0; nwr = 0; done_cnt = 0; wait_rd = 0; wait_wr = 0;
        cyc = 0; fin = 0; aborted = 0;
        cur_rl = (rd_lat < 0) ? int'($urandom_range(0, 3)) : rd_lat;
        cur_wl = (wr_lat < 0) ? int'($urandom_range(0, 3)) : wr_lat;
        while (!fin && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            abort    = 0;
            rd_data  = 8'($urandom);
            rd_valid = 1'($urandom_range(0, 1));
            wr_ready = 1'($urandom_range(0, 1));
            if (aborted) begin
                chk("abort_idle", 64'(st_v), 64'(0));
                chk("abort_rd_req", 64'(rd_req_v), 64'(0));
                chk("abort_wr_req", 64'(wr_req_v), 64'(0));
                chk("abort_no_done", 64'(done_v), 64'(0));
                fin = 1;
            end else begin
                chk("busy_in_job", 64'(busy_v), 64'(1));
                if (chaos && st_v != 3'd1) begin
                    sw_mode = 2'($urandom);
                    if (sel) btn_b = 1'($urandom_range(0, 1));
                    else     btn_a = 1'($urandom_range(0, 1));
                end
                if (rd_req_v) begin
                    chk("rd_addr", 64'(rd_addr_v), 64'((nrd < exp_rd.size()) ? exp_rd[nrd] : -1));
                    if (wait_rd >= cur_rl) begin
                        rd_valid = 1;
                        rd_data  = memval(int'(rd_addr_v), salt);
                        nrd++;
                        wait_rd  = 0;
                        cur_rl   = (rd_lat < 0) ? int'($urandom_range(0, 3)) : rd_lat;
                    end else begin
                        rd_valid = 0;
                        wait_rd++;
                    end
                end
                if (wr_req_v) begin
                    chk("wr_addr", 64'(wr_addr_v), 64'((nwr < exp_wa.size()) ? exp_wa[nwr] : -1));
                    chk("wr_data", 64'(wr_data_v),
                        64'((nwr < exp_src.size()) ? int'(memval(exp_src[nwr], salt)) : -1));
                    if (wait_wr >= cur_wl) begin
                        wr_ready = 1;
                        wait_wr  = 0;
                        cur_wl   = (wr_lat < 0) ? int'($urandom_range(0, 3)) : wr_lat;
                        if (abort_at == nwr + 1) begin
                            abort   = 1;
                            aborted = 1;
                        end else begin
                            nwr++;
                        end
                    end else begin
                        wr_ready = 0;
                        wait_wr++;
                    end
                end
                if (done_v) begin
                    done_cnt++;
                    chk("done_all_writes", 64'(nwr), 64'(exp_wa.size()));
                    chk("done_all_reads", 64'(nrd), 64'(exp_rd.size()));
                    btn_a = 0;
                    btn_b = 0;
                    fin = 1;
                end
            end
        end
        if (!fin)
            chk("job_timeout", 64'(0), 64'(1));
        if (!aborted) begin
            @(negedge clk);
            chk("idle_after_done", 64'(st_v), 64'(0));
            chk("busy_after_done", 64'(busy_v), 64'(0));
            chk("done_single_cycle", 64'(done_v), 64'(0));
            chk("done_count", 64'(done_cnt), 64'(1));
        end else begin
            repeat (4) begin
                @(negedge clk);
                chk("post_abort_state", 64'(st_v), 64'(0));
                chk("post_abort_reqs", 64'({rd_req_v, wr_req_v}), 64'(0));
                chk("post_abort_done", 64'(done_v), 64'(0));
            end
            chk("abort_write_count", 64'(nwr), 64'(abort_at - 1));
            chk("abort_done_count", 64'(done_cnt), 64'(0));
        end
        rd_valid = 0;
        wr_ready = 0;
    endtask

    initial begin
        int nrd, nwr, n, sel_r, salt;
        logic [1:0] mode_r;
        reset_n = 0; btn_a = 1; btn_b = 0; sw_mode = 0; abort = 0;
        rd_valid = 0; rd_data = 0; wr_ready = 0; sel_v = 0;
        repeat (2) @(negedge clk);
        chk_zero("reset_a");
        sel_v = 1;
        #1;
        chk_zero("reset_b");
        sel_v = 0;
        @(negedge clk);
        reset_n = 1;
        repeat (5) begin
            @(negedge clk);
            chk("held_btn_no_start", 64'(st_a), 64'(0));
        end

        run_job(0, 2'b10, 0, 0, 0, 0, 1, nrd, nwr);
        chk("down2_writes", 64'(nwr), 64'(2));
        chk("down2_reads", 64'(nrd), 64'(2));
        run_job(0, 2'b00, 0, 0, 0, 0, 2, nrd, nwr);
        chk("zoom2_writes", 64'(nwr), 64'(32));
        chk("zoom2_reads", 64'(nrd), 64'(16));
        run_job(0, 2'b01, 3, -1, 0, 0, 3, nrd, nwr);
        chk("zoom4_slow_writes", 64'(nwr), 64'(128));
        run_job(0, 2'b00, -1, 0, 5, 0, 4, nrd, nwr);
        run_job(0, 2'b10, -1, -1, 0, 0, 5, nrd, nwr);
        chk("restart_after_abort", 64'(nwr), 64'(2));
        run_job(0, 2'b01, -1, -1, 0, 1, 6, nrd, nwr);
        chk("chaos_zoom4_writes", 64'(nwr), 64'(128));
        run_job(1, 2'b10, -1, -1, 0, 0, 7, nrd, nwr);
        chk("floor_down2_writes", 64'(nwr), 64'(6));
        run_job(1, 2'b11, -1, -1, 0, 0, 8, nrd, nwr);
        chk("floor_down4_writes", 64'(nwr), 64'(1));
        run_job(1, 2'b00, -1, -1, 0, 1, 9, nrd, nwr);
        chk("chaos_b_zoom2_writes", 64'(nwr), 64'(140));

        // Asynchronous reset while the FSM waits in FETCH, button held across release.
        @(negedge clk);
        sel_v = 0; sw_mode = 2'b01; btn_a = 0; rd_valid = 0; wr_ready = 0;
        @(negedge clk);
        btn_a = 1;
        n = 0;
        while (st_a != 3'd2 && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("reach_fetch", 64'(st_a), 64'(2));
        chk("fetch_rd_req", 64'(rd_req_a), 64'(1));
        #2 reset_n = 0;
        #1;
        chk_zero("async_reset");
        @(negedge clk);
        @(negedge clk);
        reset_n = 1;
        repeat (6) begin
            @(negedge clk);
            chk("no_start_after_reset", 64'(st_a), 64'(0));
        end
        run_job(0, 2'b00, -1, -1, 0, 0, 10, nrd, nwr);
        chk("job_after_reset", 64'(nwr), 64'(32));

        for (int j = 0; j < 4; j++) begin
            sel_r  = int'($urandom_range(0, 1));
            mode_r = 2'($urandom);
            if (sel_r == 0 && mode_r == 2'b11) mode_r = 2'b10;
            salt = 20 + j;
            run_job(sel_r[0], mode_r, -1, -1, 0, 1'($urandom_range(0, 1)), salt, nrd, nwr);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
